jtl_pulse_monitor: RTL and testbench
====================================

# jtl_pulse_monitor

Clocked consumer placed directly downstream of a basic JTL stage. It receives the stage's toggle-encoded output, where each level change represents one SFQ pulse, and recovers pulse events in the `clk` domain. For each pulse it counts the pulse, measures the spacing from the previous pulse in clock cycles, and flags spacing violations. Each pulse is presented as an event record on a valid/ready interface for the vcd_assert checking flow.

## Interface
Parameters:
- `CNT_W`, 16: width of the pulse counter.
- `GAP_W`, 12: width of the gap measurement in clock cycles.
- `MIN_GAP`, 4: minimum legal spacing between consecutive pulses, in clock cycles. Range is 1 to 2^GAP_W−1.

Ports:
- `clk`  in  1  sole clock. All state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `pulse_in`  in  1  toggle-encoded JTL output, asynchronous to `clk`. Every level change is one pulse.
- `clear`  in  1  synchronous clear of the counter, flags and event register.
- `pulse_cnt`  out  CNT_W  number of pulses detected since reset or `clear`.
- `ev_valid`  out  1  an event record is held.
- `ev_ready`  in  1  the consumer accepts the held record.
- `ev_gap`  out  GAP_W  spacing, in cycles, from the previous pulse to this one.
- `ev_first`  out  1  the record is the first pulse since reset or `clear`.
- `viol`  out  1  sticky flag: a pulse spacing was below `MIN_GAP`.
- `ovf`  out  1  sticky flag: an event was dropped because the event register was held.

## Operation
- Front end:
  - `pulse_in` passes through a synchronizer (see Configuration).
  - It then goes into a history flop.
  - The detect signal `det` is the XOR of the synced value and the history value. `det` = 1 for exactly one cycle per level change.
- Gap counter `gap_cnt` (GAP_W bits):
  - Loads 1 on every edge where `det` = 1.
  - Otherwise increments each edge.
  - Saturates at all-ones.
- FSM states:
  - IDLE: no pulse seen since reset or `clear`. Goes to TRACK on `det`.
  - TRACK: goes to SAT when `gap_cnt` reaches all-ones.
  - SAT: goes to TRACK on `det`.
  - `clear` forces IDLE from any state.
- On `det`:
  - `pulse_cnt` increments, modulo 2^CNT_W. From all-ones it wraps to 0 with no flag.
  - An event record is loaded: `ev_first` = 1 and `ev_gap` = 0 in IDLE; otherwise `ev_first` = 0 and `ev_gap` = `gap_cnt`.
  - `viol` is set if the state is not IDLE and `gap_cnt` < `MIN_GAP`. A saturated gap is never a violation.
- Event handshake:
  - `ev_valid` stays high, with the record stable, until a cycle with `ev_valid` = 1 and `ev_ready` = 1.
  - `det` while `ev_valid` = 1 and `ev_ready` = 0: the new record is dropped, `ovf` is set, and the held record is kept. `pulse_cnt`, `viol` and `gap_cnt` still update.
  - `det` in the same cycle as an accepting handshake: the new record loads and `ev_valid` stays 1.
- `clear` takes priority over `det` in the same cycle. In that cycle:
  - The pulse is not counted.
  - `pulse_cnt`, `viol`, `ovf`, `ev_valid`, `ev_gap` and `ev_first` go to 0.
  - The synchronizer and history flop are not cleared, so no spurious `det` is produced.

## Timing
- Reset values:
  - All outputs are 0: `pulse_cnt`, `ev_valid`, `ev_gap`, `ev_first`, `viol`, `ovf`.
  - FSM is in IDLE and `gap_cnt` = 0.
  - The synchronizer and history flop load the current `pulse_in`, so there is no pulse on reset release.
- Latency with `JTL_MON_SYNC_EN` defined: a `pulse_in` change that is stable before edge N produces updated outputs after edge N+2.
- Latency without `JTL_MON_SYNC_EN`: updated outputs after edge N+1.
- Resolution: one level change per clock cycle. Two changes within one sample period cancel and are not detected (this is a documented limitation).
- Spacing measurement: `det` on cycles N and N+k gives `ev_gap` = k, saturating at 2^GAP_W−1.
- Reset asserted mid-operation: all of the above state is restored to its reset values on that edge.

## Configuration
- `JTL_MON_SYNC_EN` defined: a two-flop synchronizer sits before the history flop. Use for a truly asynchronous `pulse_in`.
- `JTL_MON_SYNC_EN` undefined: a single flop samples `pulse_in`. This is for benches where `pulse_in` is already aligned to `clk`; latency is reduced by one cycle.

## Structure
- Package `jtl_mon_pkg`:
  - FSM state enum `{IDLE, TRACK, SAT}`.
  - Default width constants `CNT_W_DEF` and `GAP_W_DEF`.
  - Event record struct (gap, first).
- Sub-module `toggle_edge_detect`:
  - Contains the synchronizer, the history flop and the `det` output.
  - The `JTL_MON_SYNC_EN` choice is confined to this sub-module.

## Test plan
- Reset, then 3 toggles of `pulse_in` spaced 10 cycles apart, `ev_ready` = 1 → `pulse_cnt` = 3; records (first=1, gap=0), (0, 10), (0, 10); `viol` = 0.
- Two toggles 2 cycles apart with `MIN_GAP` = 4 → second record gap = 2; `viol` = 1 and stays 1 until `clear`.
- `ev_ready` = 0, 2 pulses → first record is held; `ovf` = 1; `pulse_cnt` = 2; raising `ev_ready` delivers only the first record.
- `GAP_W` = 4, pulses 20 cycles apart → `ev_gap` = 15; FSM passes through SAT; `viol` = 0.
- `CNT_W` = 4, 17 pulses → `pulse_cnt` = 1 (wrapped).
- `clear` in the same cycle as `det` → `pulse_cnt` = 0 and `ev_valid` = 0; the next pulse gives `ev_first` = 1. Repeat the test with `JTL_MON_SYNC_EN` undefined and check latency is one cycle shorter.

Source files
------------

// File: rtl/jtl_mon_pkg.sv
// Shared types and default widths for the JTL pulse monitor.
package jtl_mon_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned GAP_W_DEF   = 12;
    localparam int unsigned MIN_GAP_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        SAT
    } mon_state_e;

    // Event record at the default gap width.
    typedef struct packed {
        logic [GAP_W_DEF-1:0] gap;
        logic                 first;
    } ev_rec_t;

endpackage

// File: rtl/toggle_edge_detect.sv
// Recovers one-cycle pulse events from a toggle-encoded input.
// JTL_MON_SYNC_EN selects a two-flop synchronizer instead of a single sample flop.
module toggle_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic det_c
);

    logic sync_q;
    logic sync_d;
    logic hist_q;
    logic hist_d;

`ifdef JTL_MON_SYNC_EN
    logic meta_q;
    logic meta_d;

    always_comb begin
        meta_d = pulse_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset preloads the current level so reset release produces no pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= pulse_in;
            sync_q <= pulse_in;
            hist_q <= pulse_in;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        sync_d = pulse_in;
        hist_d = sync_q;
    end

    // Reset preloads the current level so reset release produces no pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= pulse_in;
            hist_q <= pulse_in;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end
`endif

    assign det_c = sync_q ^ hist_q;

endmodule

// File: rtl/jtl_pulse_monitor.sv
// Counts JTL pulses, measures inter-pulse gaps and emits event records on valid/ready.
// Optional macro JTL_MON_SYNC_EN adds a two-flop synchronizer in the front end.
module jtl_pulse_monitor
    import jtl_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF,
    parameter int unsigned MIN_GAP = MIN_GAP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [GAP_W-1:0] ev_gap,
    output logic             ev_first,
    output logic             viol,
    output logic             ovf
);

    localparam logic [GAP_W-1:0] GAP_MAX   = '1;
    localparam logic [GAP_W-1:0] MIN_GAP_W = GAP_W'(MIN_GAP);

    // Event record at this instance's gap width.
    typedef struct packed {
        logic [GAP_W-1:0] gap;
        logic             first;
    } ev_rec_w_t;

    logic       det_c;
    mon_state_e state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    ev_rec_w_t  rec_q, rec_d;
    logic       ev_valid_q, ev_valid_d;
    logic       viol_q, viol_d;
    logic       ovf_q, ovf_d;

    toggle_edge_detect u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .det_c    (det_c)
    );

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        rec_d       = rec_q;
        ev_valid_d  = ev_valid_q;
        viol_d      = viol_q;
        ovf_d       = ovf_q;

        // Gap counter runs freely and is not affected by clear.
        if (det_c) begin
            gap_cnt_d = GAP_W'(1);
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end

        case (state_q)
            IDLE:    if (det_c) state_d = TRACK;
            TRACK:   if (!det_c && gap_cnt_q == GAP_MAX) state_d = SAT;
            SAT:     if (det_c) state_d = TRACK;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d     = IDLE;
            pulse_cnt_d = '0;
            rec_d       = '0;
            ev_valid_d  = 1'b0;
            viol_d      = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (ev_valid_q && ev_ready) begin
                ev_valid_d = 1'b0;
            end
            if (det_c) begin
                pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
                // A saturated gap is all-ones and can never be below MIN_GAP.
                if (state_q != IDLE && gap_cnt_q < MIN_GAP_W) begin
                    viol_d = 1'b1;
                end
                if (ev_valid_q && !ev_ready) begin
                    ovf_d = 1'b1;
                end else begin
                    rec_d.first = (state_q == IDLE);
                    rec_d.gap   = (state_q == IDLE) ? '0 : gap_cnt_q;
                    ev_valid_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            rec_q       <= '0;
            ev_valid_q  <= 1'b0;
            viol_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            rec_q       <= rec_d;
            ev_valid_q  <= ev_valid_d;
            viol_q      <= viol_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pulse_cnt = pulse_cnt_q;
    assign ev_valid  = ev_valid_q;
    assign ev_gap    = rec_q.gap;
    assign ev_first  = rec_q.first;
    assign viol      = viol_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_jtl_pulse_monitor.sv
// Directed bench for jtl_pulse_monitor: default instance plus a narrow CNT_W=4/GAP_W=4 instance.
module tb_jtl_pulse_monitor;
    import jtl_mon_pkg::*;

`ifdef JTL_MON_SYNC_EN
    localparam int unsigned DLY = 3;
`else
    localparam int unsigned DLY = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pin_a, clr_a, rdy_a;
    logic [15:0] cnt_a;
    logic [11:0] gap_a;
    logic        vld_a, first_a, viol_a, ovf_a;
    logic        pin_b, clr_b, rdy_b;
    logic [3:0]  cnt_b;
    logic [3:0]  gap_b;
    logic        vld_b, first_b, viol_b, ovf_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    jtl_pulse_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .pulse_in(pin_a), .clear(clr_a),
        .pulse_cnt(cnt_a), .ev_valid(vld_a), .ev_ready(rdy_a),
        .ev_gap(gap_a), .ev_first(first_a), .viol(viol_a), .ovf(ovf_a)
    );

    jtl_pulse_monitor #(.CNT_W(4), .GAP_W(4), .MIN_GAP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .pulse_in(pin_b), .clear(clr_b),
        .pulse_cnt(cnt_b), .ev_valid(vld_b), .ev_ready(rdy_b),
        .ev_gap(gap_b), .ev_first(first_b), .viol(viol_b), .ovf(ovf_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One toggle on instance A; checks latency, then the emitted record.
    task automatic pulse_a_chk(input bit f, input int unsigned g, input int unsigned c, input string tag);
        ev_rec_t exp_rec;
        pin_a = ~pin_a;
        wait_cyc(DLY - 1);
        check_eq({tag, "_lat"}, 32'(cnt_a), 32'(c - 1));
        wait_cyc(1);
        exp_rec.gap   = GAP_W_DEF'(g);
        exp_rec.first = f;
        check_eq({tag, "_rec"}, 32'({gap_a, first_a}), 32'(exp_rec));
        check_eq({tag, "_vld"}, 32'(vld_a), 32'(1));
        check_eq({tag, "_cnt"}, 32'(cnt_a), 32'(c));
    endtask

    initial begin
        rst_n = 1'b0;
        pin_a = 1'b0; clr_a = 1'b0; rdy_a = 1'b1;
        pin_b = 1'b0; clr_b = 1'b0; rdy_b = 1'b1;
        wait_cyc(3);
        check_eq("rst_cnt",   32'(cnt_a),   32'(0));
        check_eq("rst_vld",   32'(vld_a),   32'(0));
        check_eq("rst_gap",   32'(gap_a),   32'(0));
        check_eq("rst_first", 32'(first_a), 32'(0));
        check_eq("rst_viol",  32'(viol_a),  32'(0));
        check_eq("rst_ovf",   32'(ovf_a),   32'(0));
        check_eq("rst_cnt_b", 32'(cnt_b),   32'(0));
        rst_n = 1'b1;
        wait_cyc(2);

        // Three pulses ten cycles apart
        pulse_a_chk(1'b1, 0, 1, "t1p0");
        wait_cyc(10 - DLY);
        pulse_a_chk(1'b0, 10, 2, "t1p1");
        wait_cyc(1);
        check_eq("t1_accept", 32'(vld_a), 32'(0));
        wait_cyc(10 - DLY - 1);
        pulse_a_chk(1'b0, 10, 3, "t1p2");
        check_eq("t1_viol", 32'(viol_a), 32'(0));

        // Two pulses two cycles apart -> violation, sticky until clear
        clr_a = 1'b1; wait_cyc(1); clr_a = 1'b0;
        check_eq("t2_clr_cnt", 32'(cnt_a), 32'(0));
        check_eq("t2_clr_vld", 32'(vld_a), 32'(0));
        pin_a = ~pin_a; wait_cyc(2);
        pin_a = ~pin_a; wait_cyc(DLY);
        check_eq("t2_gap",   32'(gap_a),   32'(2));
        check_eq("t2_first", 32'(first_a), 32'(0));
        check_eq("t2_cnt",   32'(cnt_a),   32'(2));
        check_eq("t2_viol",  32'(viol_a),  32'(1));
        wait_cyc(20);
        check_eq("t2_sticky", 32'(viol_a), 32'(1));
        clr_a = 1'b1; wait_cyc(1); clr_a = 1'b0;
        check_eq("t2_viol_clr", 32'(viol_a), 32'(0));

        // Held record with ready low -> second record dropped
        rdy_a = 1'b0;
        pin_a = ~pin_a; wait_cyc(6);
        pin_a = ~pin_a; wait_cyc(6);
        check_eq("t3_vld",   32'(vld_a),   32'(1));
        check_eq("t3_first", 32'(first_a), 32'(1));
        check_eq("t3_gap",   32'(gap_a),   32'(0));
        check_eq("t3_ovf",   32'(ovf_a),   32'(1));
        check_eq("t3_cnt",   32'(cnt_a),   32'(2));
        check_eq("t3_viol",  32'(viol_a),  32'(0));
        rdy_a = 1'b1; wait_cyc(1);
        check_eq("t3_drain", 32'(vld_a), 32'(0));
        wait_cyc(3);
        check_eq("t3_nomore", 32'(vld_a), 32'(0));

        // Clear in the same cycle as det
        pin_a = ~pin_a; wait_cyc(DLY - 1);
        clr_a = 1'b1; wait_cyc(1); clr_a = 1'b0;
        check_eq("t4_cnt",   32'(cnt_a),   32'(0));
        check_eq("t4_vld",   32'(vld_a),   32'(0));
        check_eq("t4_ovf",   32'(ovf_a),   32'(0));
        check_eq("t4_first", 32'(first_a), 32'(0));
        wait_cyc(5);
        check_eq("t4_nospur", 32'(cnt_a), 32'(0));
        pulse_a_chk(1'b1, 0, 1, "t4p");

        // Narrow instance: gap saturation at 15
        pin_b = ~pin_b; wait_cyc(20);
        pin_b = ~pin_b; wait_cyc(DLY);
        check_eq("t5_gap",   32'(gap_b),   32'(15));
        check_eq("t5_first", 32'(first_b), 32'(0));
        check_eq("t5_vld",   32'(vld_b),   32'(1));
        check_eq("t5_viol",  32'(viol_b),  32'(0));
        check_eq("t5_cnt",   32'(cnt_b),   32'(2));

        // Narrow instance: counter wraps after 16 pulses
        clr_b = 1'b1; wait_cyc(1); clr_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pin_b = ~pin_b; wait_cyc(5);
        end
        check_eq("t6_wrap0", 32'(cnt_b), 32'(0));
        pin_b = ~pin_b; wait_cyc(5);
        check_eq("t6_wrap1", 32'(cnt_b), 32'(1));
        check_eq("t6_viol",  32'(viol_b), 32'(0));
        check_eq("t6_ovf",   32'(ovf_b),  32'(0));

        // Back-to-back changes, then reset mid-operation
        pin_a = ~pin_a; wait_cyc(1);
        pin_a = ~pin_a; wait_cyc(DLY + 1);
        check_eq("t7_cnt",  32'(cnt_a),  32'(3));
        check_eq("t7_viol", 32'(viol_a), 32'(1));
        rst_n = 1'b0; wait_cyc(1);
        check_eq("t7_rst_cnt",   32'(cnt_a),   32'(0));
        check_eq("t7_rst_viol",  32'(viol_a),  32'(0));
        check_eq("t7_rst_vld",   32'(vld_a),   32'(0));
        check_eq("t7_rst_first", 32'(first_a), 32'(0));
        check_eq("t7_rst_gap",   32'(gap_a),   32'(0));
        check_eq("t7_rst_cnt_b", 32'(cnt_b),   32'(0));
        rst_n = 1'b1; wait_cyc(5);
        check_eq("t7_post_cnt", 32'(cnt_a), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
